decode_cycle: RTL and testbench
===============================

Name: decode_cycle

Overview:
Second pipeline stage of the 5-stage RV32I core, directly downstream of fetch_cycle. It consumes InstrD/PCD/PCNextD, decodes control, reads the 32x32 register file and sign-extends immediates. The register file is written by the writeback stage. All results are registered into the ID/EX pipeline register that feeds execute.

Parameters:
XLEN, 32, datapath width
NREGS, 32, architectural register count; x0 hardwired to zero

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
InstrD  in  32  instruction from fetch
PCD  in  32  PC of InstrD
PCNextD  in  32  PCD+4 from fetch
RegWriteW  in  1  writeback enable
RdW  in  5  writeback destination
ResultW  in  32  writeback data
FlushE  in  1  hazard unit: bubble ID/EX on next edge
Rs1D, Rs2D  out  5 each  combinational InstrD[19:15], InstrD[24:20], for the hazard unit
RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1 each  registered control
ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
RD1E, RD2E  out  32  registered operands
ImmExtE  out  32  registered sign-extended immediate
RdE, Rs1E, Rs2E  out  5 each  registered register indices
PCE, PCNextE  out  32  registered PCD, PCNextD

Behaviour:
- Reset (rst=0, asynchronous): every ID/EX output = 0; all 32 registers cleared to 0. Release is synchronous to the next rising edge.
- Latency: 1 cycle. Values decoded from InstrD in cycle N appear on the *E outputs after edge N+1.
- Register file: write on the rising edge when RegWriteW=1 and RdW!=0. Writes to x0 are ignored. Reads of x0 always return 0.
- Write-through bypass: if RegWriteW=1, RdW!=0 and RdW equals rs1 (or rs2), that read returns ResultW in the same cycle.
- Main decode, by opcode:
  - 0000011 lw: RegWrite=1, ImmSrc I, ALUSrc=1, ResultSrc=01, ALUOp=00.
  - 0100011 sw: MemWrite=1, ImmSrc S, ALUSrc=1, ALUOp=00.
  - 0110011 R-type: RegWrite=1, ALUOp=10.
  - 1100011 beq: Branch=1, ImmSrc B, ALUOp=01.
  - 0010011 I-ALU: RegWrite=1, ImmSrc I, ALUSrc=1, ALUOp=10.
  - 1101111 jal: RegWrite=1, Jump=1, ImmSrc J, ResultSrc=10.
- Any other opcode: all control 0, so the instruction behaves as a bubble.
- ALU decode:
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10, by funct3: 000 -> sub only when opcode is R-type and funct7[5]=1, else add; 010 -> slt; 110 -> or; 111 -> and; any other funct3 -> add.
- Immediates, all sign-extended from InstrD[31]:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - J: {[31],[19:12],[20],[30:21],0}.
- FlushE=1 at an edge: all ID/EX control, RdE, Rs1E and Rs2E load 0. Data fields may also load 0. FlushE has priority over normal capture.
- Simultaneous writeback and decode of the same register: bypassed value is captured.
- Reset asserted mid-operation: outputs clear immediately, without waiting for a clock edge.

Decomposition:
- Shared package holds: opcode constants, ALUControl encodings, ResultSrc encodings, ImmSrc encodings (00 I, 01 S, 10 B, 11 J).
- Sub-modules: control_unit (main decoder + ALU decoder, combinational) and register_file (32x32 with bypass). Immediate extension is inline.

Test Plan:
- rst=0 mid-run with non-zero outputs -> all *E outputs 0 at once, before any clock edge.
- InstrD=0x00500093 (addi x1,x0,5) -> next edge: RegWriteE=1, ALUSrcE=1, ALUControlE=000, ImmExtE=5, RdE=1, RD1E=0.
- Write x1=7 and x2=3 via the W port, then InstrD=0x402081B3 (sub x3,x1,x2) -> ALUControlE=001, RD1E=7, RD2E=3, RdE=3.
- RegWriteW=1, RdW=2, ResultW=0xAA in the same cycle InstrD=0x002081B3 -> RD2E=0xAA (bypass). RdW=0, ResultW=0x55 -> later reads of x0 return 0.
- InstrD=0xFE208CE3 (beq x1,x2,-8) -> BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFF8. InstrD=0xFFC12283 (lw x5,-4(x2)) -> ResultSrcE=01, ImmExtE=0xFFFFFFFC.
- InstrD=0x00512423 (sw x5,8(x2)) with FlushE=1 -> all control 0, RdE=0. Same instruction with FlushE=0 -> MemWriteE=1, ImmExtE=8.

Source files
------------

// File: rtl/decode_cycle_pkg.sv
// -----------------------------------------------------------------------------
// decode_cycle_pkg
// Shared definitions for the RV32I decode stage: datapath sizes, opcode
// constants, control-field encodings and the layout of the ID/EX pipeline
// register.
// -----------------------------------------------------------------------------
package decode_cycle_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    // Opcodes recognised by the main decoder; anything else decodes as a bubble.
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    // Class of ALU operation requested by the main decoder.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    // Contents of the ID/EX pipeline register.
    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic              jump;
        logic              branch;
        logic              alu_src;
        logic [1:0]        result_src;
        logic [2:0]        alu_control;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm_ext;
        logic [AW-1:0]     rd;
        logic [AW-1:0]     rs1;
        logic [AW-1:0]     rs2;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc_next;
    } id_ex_t;

endpackage

// File: rtl/decode_cycle_control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
// Combinational main decoder plus ALU decoder.
//   i_opcode      : InstrD[6:0]
//   i_funct3      : InstrD[14:12]
//   i_funct7b5    : InstrD[30]
//   o_reg_write, o_mem_write, o_jump, o_branch, o_alu_src : control bits
//   o_result_src  : writeback source select
//   o_imm_src     : immediate format select
//   o_alu_control : ALU operation
// -----------------------------------------------------------------------------
module control_unit
    import decode_cycle_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    output logic       o_reg_write,
    output logic       o_mem_write,
    output logic       o_jump,
    output logic       o_branch,
    output logic       o_alu_src,
    output logic [1:0] o_result_src,
    output logic [1:0] o_imm_src,
    output logic [2:0] o_alu_control
);

    alu_op_e w_alu_op;
    logic    w_is_rtype;

    assign w_is_rtype = (i_opcode == OP_RTYPE);

    // Main decoder.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        o_reg_write  = 1'b0;
        o_mem_write  = 1'b0;
        o_jump       = 1'b0;
        o_branch     = 1'b0;
        o_alu_src    = 1'b0;
        o_result_src = RES_ALU;
        o_imm_src    = IMM_I;
        w_alu_op     = ALUOP_ADD;
        case (i_opcode)
            OP_LW: begin
                o_reg_write  = 1'b1;
                o_alu_src    = 1'b1;
                o_result_src = RES_MEM;
                o_imm_src    = IMM_I;
            end
            OP_SW: begin
                o_mem_write  = 1'b1;
                o_alu_src    = 1'b1;
                o_imm_src    = IMM_S;
            end
            OP_RTYPE: begin
                o_reg_write  = 1'b1;
                w_alu_op     = ALUOP_FUNCT;
            end
            OP_BEQ: begin
                o_branch     = 1'b1;
                o_imm_src    = IMM_B;
                w_alu_op     = ALUOP_SUB;
            end
            OP_IALU: begin
                o_reg_write  = 1'b1;
                o_alu_src    = 1'b1;
                o_imm_src    = IMM_I;
                w_alu_op     = ALUOP_FUNCT;
            end
            OP_JAL: begin
                o_reg_write  = 1'b1;
                o_jump       = 1'b1;
                o_imm_src    = IMM_J;
                o_result_src = RES_PC4;
            end
            default: ;
        endcase
    end

    // ALU decoder. funct7[5] selects sub only for register-register ops;
    // for I-ALU ops that bit belongs to the immediate.
    always_comb begin
        o_alu_control = ALU_ADD;
        case (w_alu_op)
            ALUOP_ADD: o_alu_control = ALU_ADD;
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    3'b000:  o_alu_control = (w_is_rtype && i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/decode_cycle_register_file.sv
// -----------------------------------------------------------------------------
// register_file
// 32 x 32 architectural register file, x0 hardwired to zero, with a
// write-through bypass so a read of the register being written this cycle
// returns the incoming data.
//   clk, rst_n       : clock, asynchronous active-low reset (clears all regs)
//   i_we, i_waddr, i_wdata : writeback port
//   i_raddr1/2       : read addresses
//   o_rdata1/2       : combinational read data
// -----------------------------------------------------------------------------
module register_file
    import decode_cycle_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr1,
    input  logic [AW-1:0]   i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_write_en;

    assign w_write_en = i_we && (i_waddr != '0);

    // NOTE: the array is reset because the architecture requires all registers
    // to read zero after reset; this rules out mapping it onto RAM macros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_write_en) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // x0 check first so a (blocked) write to x0 can never leak through the bypass.
    always_comb begin
        o_rdata1 = r_regs[i_raddr1];
        if (i_raddr1 == '0)
            o_rdata1 = '0;
        else if (w_write_en && (i_waddr == i_raddr1))
            o_rdata1 = i_wdata;
    end

    always_comb begin
        o_rdata2 = r_regs[i_raddr2];
        if (i_raddr2 == '0)
            o_rdata2 = '0;
        else if (w_write_en && (i_waddr == i_raddr2))
            o_rdata2 = i_wdata;
    end

endmodule

// File: rtl/decode_cycle.sv
// -----------------------------------------------------------------------------
// decode_cycle
// Decode stage of the 5-stage RV32I pipeline. Decodes InstrD, reads the
// register file, sign-extends the immediate and registers everything into the
// ID/EX pipeline register.
//   clk, rst            : clock, asynchronous active-low reset
//   InstrD, PCD, PCNextD: instruction and PCs from fetch
//   RegWriteW, RdW, ResultW : register-file write from writeback
//   FlushE              : bubble the ID/EX register at the next edge
//   Rs1D, Rs2D          : combinational source indices for the hazard unit
//   *E outputs          : registered ID/EX contents
// -----------------------------------------------------------------------------
module decode_cycle
    import decode_cycle_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCNextD,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    input  logic        FlushE,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        JumpE,
    output logic        BranchE,
    output logic        ALUSrcE,
    output logic [1:0]  ResultSrcE,
    output logic [2:0]  ALUControlE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [4:0]  RdE,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic [31:0] PCE,
    output logic [31:0] PCNextE
);

    logic            w_reg_write;
    logic            w_mem_write;
    logic            w_jump;
    logic            w_branch;
    logic            w_alu_src;
    logic [1:0]      w_result_src;
    logic [1:0]      w_imm_src;
    logic [2:0]      w_alu_control;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;
    logic [XLEN-1:0] w_imm_ext;
    id_ex_t          w_id_ex;
    id_ex_t          r_id_ex;

    assign Rs1D = InstrD[19:15];
    assign Rs2D = InstrD[24:20];

    control_unit u_control_unit (
        .i_opcode      (InstrD[6:0]),
        .i_funct3      (InstrD[14:12]),
        .i_funct7b5    (InstrD[30]),
        .o_reg_write   (w_reg_write),
        .o_mem_write   (w_mem_write),
        .o_jump        (w_jump),
        .o_branch      (w_branch),
        .o_alu_src     (w_alu_src),
        .o_result_src  (w_result_src),
        .o_imm_src     (w_imm_src),
        .o_alu_control (w_alu_control)
    );

    register_file u_register_file (
        .clk      (clk),
        .rst_n    (rst),
        .i_we     (RegWriteW),
        .i_waddr  (RdW),
        .i_wdata  (ResultW),
        .i_raddr1 (InstrD[19:15]),
        .i_raddr2 (InstrD[24:20]),
        .o_rdata1 (w_rd1),
        .o_rdata2 (w_rd2)
    );

    // Immediate extension; every format sign-extends from InstrD[31].
    always_comb begin
        w_imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
        case (w_imm_src)
            IMM_I:   w_imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
            IMM_S:   w_imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B:   w_imm_ext = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25],
                                  InstrD[11:8], 1'b0};
            IMM_J:   w_imm_ext = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20],
                                  InstrD[30:21], 1'b0};
            default: ;
        endcase
    end

    always_comb begin
        w_id_ex.reg_write   = w_reg_write;
        w_id_ex.mem_write   = w_mem_write;
        w_id_ex.jump        = w_jump;
        w_id_ex.branch      = w_branch;
        w_id_ex.alu_src     = w_alu_src;
        w_id_ex.result_src  = w_result_src;
        w_id_ex.alu_control = w_alu_control;
        w_id_ex.rd1         = w_rd1;
        w_id_ex.rd2         = w_rd2;
        w_id_ex.imm_ext     = w_imm_ext;
        w_id_ex.rd          = InstrD[11:7];
        w_id_ex.rs1         = InstrD[19:15];
        w_id_ex.rs2         = InstrD[24:20];
        w_id_ex.pc          = PCD;
        w_id_ex.pc_next     = PCNextD;
    end

    // ID/EX register. A flush loads a complete bubble (data fields included)
    // and wins over normal capture.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_id_ex <= '0;
        else if (FlushE)
            r_id_ex <= '0;
        else
            r_id_ex <= w_id_ex;
    end

    assign RegWriteE   = r_id_ex.reg_write;
    assign MemWriteE   = r_id_ex.mem_write;
    assign JumpE       = r_id_ex.jump;
    assign BranchE     = r_id_ex.branch;
    assign ALUSrcE     = r_id_ex.alu_src;
    assign ResultSrcE  = r_id_ex.result_src;
    assign ALUControlE = r_id_ex.alu_control;
    assign RD1E        = r_id_ex.rd1;
    assign RD2E        = r_id_ex.rd2;
    assign ImmExtE     = r_id_ex.imm_ext;
    assign RdE         = r_id_ex.rd;
    assign Rs1E        = r_id_ex.rs1;
    assign Rs2E        = r_id_ex.rs2;
    assign PCE         = r_id_ex.pc;
    assign PCNextE     = r_id_ex.pc_next;

endmodule

// File: tb/tb_decode_cycle.sv
// -----------------------------------------------------------------------------
// tb_decode_cycle
// Directed vectors with hand-decoded expectations pushed into a scoreboard
// queue; a monitor pops one entry after each rising edge and compares.
// -----------------------------------------------------------------------------
module tb_decode_cycle;

    logic        clk;
    logic        rst;
    logic [31:0] InstrD, PCD, PCNextD, ResultW;
    logic        RegWriteW, FlushE;
    logic [4:0]  RdW;
    logic [4:0]  Rs1D, Rs2D;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCNextE;
    logic [4:0]  RdE, Rs1E, Rs2E;

    decode_cycle dut (
        .clk         (clk),
        .rst         (rst),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCNextD     (PCNextD),
        .RegWriteW   (RegWriteW),
        .RdW         (RdW),
        .ResultW     (ResultW),
        .FlushE      (FlushE),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .JumpE       (JumpE),
        .BranchE     (BranchE),
        .ALUSrcE     (ALUSrcE),
        .ResultSrcE  (ResultSrcE),
        .ALUControlE (ALUControlE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .ImmExtE     (ImmExtE),
        .RdE         (RdE),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .PCE         (PCE),
        .PCNextE     (PCNextE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  ctrl;      // {RegWrite, MemWrite, Jump, Branch, ALUSrc}
        logic [1:0]  rsrc;
        logic [2:0]  aluc;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] rd1, rd2, imm, pc, pcn;
        bit          chk_data;  // operands, PCs (skipped for flushed entries)
        bit          chk_imm;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input string n, input logic [4:0] ctrl, input logic [1:0] rsrc,
                                input logic [2:0] aluc, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [31:0] imm, input bit chk_imm);
        exp_t e;
        e.name = n; e.ctrl = ctrl; e.rsrc = rsrc; e.aluc = aluc;
        e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.rd1 = rd1; e.rd2 = rd2; e.imm = imm;
        e.pc = '0; e.pcn = '0; e.chk_data = 1'b1; e.chk_imm = chk_imm;
        return e;
    endfunction

    // Drive one decode cycle at the falling edge and queue its expectation.
    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic flush,
                         input logic we, input logic [4:0] rdw, input logic [31:0] resw,
                         input exp_t e);
        exp_t ee;
        @(negedge clk);
        InstrD = instr; PCD = pc; PCNextD = pc + 32'd4; FlushE = flush;
        RegWriteW = we; RdW = rdw; ResultW = resw;
        ee = e;
        ee.pc = pc; ee.pcn = pc + 32'd4;
        if (flush) ee.chk_data = 1'b0;
        q.push_back(ee);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drain", q.size(), 0);
    endtask

    // Monitor: the ID/EX register updates on every edge, so each queued entry
    // is due one edge after it was issued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check({e.name, ".ctrl"}, {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE}, e.ctrl);
                check({e.name, ".rsrc"}, ResultSrcE, e.rsrc);
                check({e.name, ".aluc"}, ALUControlE, e.aluc);
                check({e.name, ".rd"},   RdE, e.rd);
                check({e.name, ".rs1"},  Rs1E, e.rs1);
                check({e.name, ".rs2"},  Rs2E, e.rs2);
                if (e.chk_data) begin
                    check({e.name, ".rd1"}, RD1E, e.rd1);
                    check({e.name, ".rd2"}, RD2E, e.rd2);
                    check({e.name, ".pc"},  PCE, e.pc);
                    check({e.name, ".pcn"}, PCNextE, e.pcn);
                    if (e.chk_imm) check({e.name, ".imm"}, ImmExtE, e.imm);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; InstrD = '0; PCD = '0; PCNextD = '0;
        RegWriteW = 1'b0; RdW = '0; ResultW = '0; FlushE = 1'b0;

        // Reset state, before and after clock edges under reset.
        #3;
        check("rst0.regwrite", RegWriteE, 0);
        check("rst0.rd1", RD1E, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst1.pce", PCE, 0);
        check("rst1.aluc", ALUControlE, 0);
        @(negedge clk);
        rst = 1'b1;

        // addi x1,x0,5
        drive(32'h00500093, 32'h1000, 0, 0, 0, 0,
              mk("addi", 5'b10001, 2'b00, 3'b000, 5'd1, 5'd0, 5'd5, 0, 0, 32'd5, 1));
        check("rs1d", Rs1D, 0);
        check("rs2d", Rs2D, 5);
        // Bubbles while x1=7 and x2=3 are written via the W port.
        drive(32'h00000000, 32'h1004, 0, 1, 5'd1, 32'd7,
              mk("wr_x1", 5'b00000, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 1));
        drive(32'h00000000, 32'h1008, 0, 1, 5'd2, 32'd3,
              mk("wr_x2", 5'b00000, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 1));
        // sub x3,x1,x2
        drive(32'h402081B3, 32'h100C, 0, 0, 0, 0,
              mk("sub", 5'b10000, 2'b00, 3'b001, 5'd3, 5'd1, 5'd2, 32'd7, 32'd3, 0, 0));
        check("rs1d_sub", Rs1D, 1);
        // add x3,x1,x2 while x2 <= 0xAA: bypass
        drive(32'h002081B3, 32'h1010, 0, 1, 5'd2, 32'hAA,
              mk("bypass", 5'b10000, 2'b00, 3'b000, 5'd3, 5'd1, 5'd2, 32'd7, 32'hAA, 0, 0));
        // addi x1,x0,0 while writing x0: no bypass onto x0
        drive(32'h00000093, 32'h1014, 0, 1, 5'd0, 32'h55,
              mk("x0_wr", 5'b10001, 2'b00, 3'b000, 5'd1, 5'd0, 5'd0, 0, 0, 0, 1));
        // nop: x0 still reads 0 after the ignored write
        drive(32'h00000013, 32'h1018, 0, 0, 0, 0,
              mk("x0_rd", 5'b10001, 2'b00, 3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1));
        // beq x1,x2,-8
        drive(32'hFE208CE3, 32'h101C, 0, 0, 0, 0,
              mk("beq", 5'b00010, 2'b00, 3'b001, 5'd25, 5'd1, 5'd2, 32'd7, 32'hAA, 32'hFFFFFFF8, 1));
        // lw x5,-4(x2)
        drive(32'hFFC12283, 32'h1020, 0, 0, 0, 0,
              mk("lw", 5'b10001, 2'b01, 3'b000, 5'd5, 5'd2, 5'd28, 32'hAA, 0, 32'hFFFFFFFC, 1));
        // sw x5,8(x2) flushed, then not flushed
        drive(32'h00512423, 32'h1024, 1, 0, 0, 0,
              mk("sw_flush", 5'b00000, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 0));
        drive(32'h00512423, 32'h1028, 0, 0, 0, 0,
              mk("sw", 5'b01001, 2'b00, 3'b000, 5'd8, 5'd2, 5'd5, 32'hAA, 0, 32'd8, 1));
        // jal x1,8
        drive(32'h008000EF, 32'h102C, 0, 0, 0, 0,
              mk("jal", 5'b10100, 2'b10, 3'b000, 5'd1, 5'd0, 5'd8, 0, 0, 32'd8, 1));
        // slti x2,x1,-1
        drive(32'hFFF0A113, 32'h1030, 0, 0, 0, 0,
              mk("slti", 5'b10001, 2'b00, 3'b101, 5'd2, 5'd1, 5'd31, 32'd7, 0, 32'hFFFFFFFF, 1));
        // addi x4,x1,0x400: bit30 set but I-type stays add
        drive(32'h40008213, 32'h1034, 0, 0, 0, 0,
              mk("addi_b30", 5'b10001, 2'b00, 3'b000, 5'd4, 5'd1, 5'd0, 32'd7, 0, 32'h400, 1));
        // and x6,x1,x2 / or x6,x1,x2
        drive(32'h0020F333, 32'h1038, 0, 0, 0, 0,
              mk("and", 5'b10000, 2'b00, 3'b010, 5'd6, 5'd1, 5'd2, 32'd7, 32'hAA, 0, 0));
        drive(32'h0020E333, 32'h103C, 0, 0, 0, 0,
              mk("or", 5'b10000, 2'b00, 3'b011, 5'd6, 5'd1, 5'd2, 32'd7, 32'hAA, 0, 0));
        wait_drain();

        // Mid-run asynchronous reset: outputs clear before the next edge.
        #2;
        rst = 1'b0;
        #1;
        check("arst.regwrite", RegWriteE, 0);
        check("arst.aluc", ALUControlE, 0);
        check("arst.rd1", RD1E, 0);
        check("arst.rd2", RD2E, 0);
        check("arst.rde", RdE, 0);
        check("arst.pce", PCE, 0);
        @(negedge clk);
        rst = 1'b1;
        // Register file was cleared by reset.
        drive(32'h002081B3, 32'h2000, 0, 0, 0, 0,
              mk("post_rst", 5'b10000, 2'b00, 3'b000, 5'd3, 5'd1, 5'd2, 0, 0, 0, 0));
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
